// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall/bubble, EX operand forwarding, ID write-back bypass, redirect flush.
// Optional HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt event counters.
module pipe_hazard_ctrl #(
   parameter int RIDX_W = 5,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [RIDX_W-1:0] id_rs,
   input  logic [RIDX_W-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [RIDX_W-1:0] id_rw,
   input  logic              id_regwr,
   input  logic              id_memtoreg,
   input  logic              redirect,
   output logic              stall,
   output logic              bubble,
   output logic              flush_if,
   output logic              flush_id,
   output logic              flush_ex,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              byp_a,
   output logic              byp_b
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic [RIDX_W-1:0] rw;
      logic              regwr;
      logic              memtoreg;
   } rec_t;

   localparam rec_t REC_NONE = '{valid: 1'b0, rw: {RIDX_W{1'b0}}, regwr: 1'b0, memtoreg: 1'b0};

   // Register 0 is hard-wired zero and never participates in a dependency.
   function automatic logic live_idx(input logic [RIDX_W-1:0] idx);
      return (idx != {RIDX_W{1'b0}}) && (int'(idx) < NREG);
   endfunction

   function automatic logic writes(input logic valid, input logic regwr,
                                   input logic [RIDX_W-1:0] rw, input logic [RIDX_W-1:0] idx);
      return valid && regwr && live_idx(rw) && (rw == idx);
   endfunction

   rec_t       ex_r, mem_r, wb_r;
   logic [1:0] fwd_a_r, fwd_b_r;
   logic [1:0] fwd_a_nxt_s, fwd_b_nxt_s;
   logic       rs_live_s, rt_live_s;
   logic       load_use_s, capture_s;
   logic       unused_s;

   assign rs_live_s = id_valid && id_use_rs && live_idx(id_rs);
   assign rt_live_s = id_valid && id_use_rt && live_idx(id_rt);

   assign load_use_s = ex_r.memtoreg &&
                       ((rs_live_s && writes(ex_r.valid, ex_r.regwr, ex_r.rw, id_rs)) ||
                        (rt_live_s && writes(ex_r.valid, ex_r.regwr, ex_r.rw, id_rt)));

   // The ID instruction enters EX only when it is live and neither bubbled nor flushed.
   assign capture_s = id_valid && !load_use_s && !redirect;

   // Only the EX record's load flag matters for hazards; later stages keep it for completeness.
   assign unused_s = mem_r.memtoreg ^ wb_r.memtoreg;

   // Hazard, flush and bypass outputs; redirect overrides load-use, reset silences everything.
   always_comb begin
      stall    = 1'b0;
      bubble   = 1'b0;
      flush_if = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      byp_a    = 1'b0;
      byp_b    = 1'b0;
      if (rst_n) begin
         if (redirect) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
            flush_ex = 1'b1;
         end else if (load_use_s) begin
            stall  = 1'b1;
            bubble = 1'b1;
         end else begin
            stall  = 1'b0;
            bubble = 1'b0;
         end
         byp_a = rs_live_s && writes(wb_r.valid, wb_r.regwr, wb_r.rw, id_rs);
         byp_b = rt_live_s && writes(wb_r.valid, wb_r.regwr, wb_r.rw, id_rt);
      end else begin
         stall = 1'b0;
      end
   end

   // Forward select for the next EX cycle: the newest in-flight producer wins.
   always_comb begin
      fwd_a_nxt_s = 2'd0;
      fwd_b_nxt_s = 2'd0;
      if (rs_live_s && writes(ex_r.valid, ex_r.regwr, ex_r.rw, id_rs)) begin
         fwd_a_nxt_s = 2'd1;
      end else if (rs_live_s && writes(mem_r.valid, mem_r.regwr, mem_r.rw, id_rs)) begin
         fwd_a_nxt_s = 2'd2;
      end else begin
         fwd_a_nxt_s = 2'd0;
      end
      if (rt_live_s && writes(ex_r.valid, ex_r.regwr, ex_r.rw, id_rt)) begin
         fwd_b_nxt_s = 2'd1;
      end else if (rt_live_s && writes(mem_r.valid, mem_r.regwr, mem_r.rw, id_rt)) begin
         fwd_b_nxt_s = 2'd2;
      end else begin
         fwd_b_nxt_s = 2'd0;
      end
   end

   // Shadow pipeline records and registered forward selects.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_r    <= REC_NONE;
         mem_r   <= REC_NONE;
         wb_r    <= REC_NONE;
         fwd_a_r <= 2'd0;
         fwd_b_r <= 2'd0;
      end else begin
         if (capture_s) begin
            ex_r <= '{valid: 1'b1, rw: id_rw, regwr: id_regwr, memtoreg: id_memtoreg};
         end else begin
            ex_r <= REC_NONE;
         end
         if (redirect) begin
            mem_r <= REC_NONE;
         end else begin
            mem_r <= ex_r;
         end
         wb_r <= mem_r;
         if (capture_s) begin
            fwd_a_r <= fwd_a_nxt_s;
            fwd_b_r <= fwd_b_nxt_s;
         end else begin
            fwd_a_r <= 2'd0;
            fwd_b_r <= 2'd0;
         end
      end
   end

   assign fwd_a = fwd_a_r;
   assign fwd_b = fwd_b_r;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_r, flush_cnt_r;

   // Event counters wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (stall) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (redirect) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic vs an in-bench model.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, id_valid, id_use_rs, id_use_rt, id_regwr, id_memtoreg, redirect;
   logic [4:0] id_rs, id_rt, id_rw;
   logic       stall, bubble, flush_if, flush_id, flush_ex, byp_a, byp_b;
   logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RIDX_W(5), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
      .id_memtoreg(id_memtoreg), .redirect(redirect), .stall(stall), .bubble(bubble),
      .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex), .fwd_a(fwd_a),
      .fwd_b(fwd_b), .byp_a(byp_a), .byp_b(byp_b)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // Model: instructions in flight, indexed by how many stages past ID they are (0=EX,1=MEM,2=WB).
   typedef struct {
      bit v;
      int rw;
      bit wr;
      bit ld;
   } instr_t;

   instr_t      age[3];
   instr_t      none_i = '{v: 1'b0, rw: 0, wr: 1'b0, ld: 1'b0};
   int          exp_fwd_a = 0, exp_fwd_b = 0;
   int unsigned m_scnt = 0, m_fcnt = 0;
   bit          m_stall = 1'b0;
   bit          chk_en = 1'b0;
   int          n_chk = 0, n_fail = 0;

   function automatic bit produces(instr_t p, int idx);
      return p.v && p.wr && (idx != 0) && (p.rw == idx);
   endfunction

   // Forward code = 1 + age of the youngest producer still before write-back, else 0.
   function automatic int newest(int idx);
      for (int a = 0; a < 2; a++)
         if (produces(age[a], idx)) return a + 1;
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, then advance the model across the coming edge.
   always @(negedge clk) begin : cmp
      bit rs_l, rt_l, lu, st, fl, ba, bb;
      int na, nb;
      if (chk_en) begin
         rs_l = id_valid && id_use_rs && (id_rs != 5'd0);
         rt_l = id_valid && id_use_rt && (id_rt != 5'd0);
         lu   = age[0].ld && ((rs_l && produces(age[0], int'(id_rs))) ||
                              (rt_l && produces(age[0], int'(id_rt))));
         st   = rst_n && !redirect && lu;
         fl   = rst_n && redirect;
         ba   = rst_n && rs_l && produces(age[2], int'(id_rs));
         bb   = rst_n && rt_l && produces(age[2], int'(id_rt));
         chk("m_stall", 32'(stall), 32'(st));
         chk("m_bubble", 32'(bubble), 32'(st));
         chk("m_flush_if", 32'(flush_if), 32'(fl));
         chk("m_flush_id", 32'(flush_id), 32'(fl));
         chk("m_flush_ex", 32'(flush_ex), 32'(fl));
         chk("m_byp_a", 32'(byp_a), 32'(ba));
         chk("m_byp_b", 32'(byp_b), 32'(bb));
         chk("m_fwd_a", 32'(fwd_a), 32'(exp_fwd_a));
         chk("m_fwd_b", 32'(fwd_b), 32'(exp_fwd_b));
`ifdef HAZARD_PERF_CNT_EN
         chk("m_stall_cnt", stall_cnt, m_scnt);
         chk("m_flush_cnt", flush_cnt, m_fcnt);
`endif
         if (!rst_n) begin
            for (int a = 0; a < 3; a++) age[a] = none_i;
            exp_fwd_a = 0;
            exp_fwd_b = 0;
            m_scnt    = 0;
            m_fcnt    = 0;
         end else begin
            na = (rs_l && !lu && !redirect) ? newest(int'(id_rs)) : 0;
            nb = (rt_l && !lu && !redirect) ? newest(int'(id_rt)) : 0;
            exp_fwd_a = na;
            exp_fwd_b = nb;
            age[2] = age[1];
            age[1] = redirect ? none_i : age[0];
            if (id_valid && !lu && !redirect)
               age[0] = '{v: 1'b1, rw: int'(id_rw), wr: id_regwr, ld: id_memtoreg};
            else
               age[0] = none_i;
            m_scnt = m_scnt + 32'(st);
            m_fcnt = m_fcnt + 32'(redirect);
         end
         m_stall = st;
      end
   end

   task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rw, input bit wr, input bit ld, input bit rd, input bit rn);
      @(posedge clk);
      #1;
      rst_n = rn; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs;
      id_use_rt = urt; id_rw = 5'(rw); id_regwr = wr; id_memtoreg = ld; redirect = rd;
      @(negedge clk);
      #1;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0;
      id_use_rt = 1'b0; id_rw = 5'd0; id_regwr = 1'b0; id_memtoreg = 1'b0; redirect = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      nop(3);

      // lw r8 ; add r9,r8,r1
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 1);
      drive(1, 8, 1, 1, 1, 9, 1, 0, 0, 1);
      chk("lu_stall", 32'(stall), 32'd1);
      chk("lu_bubble", 32'(bubble), 32'd1);
      drive(1, 8, 1, 1, 1, 9, 1, 0, 0, 1);
      chk("lu_no_second_stall", 32'(stall), 32'd0);
      nop(1);
      chk("lu_fwd_a", 32'(fwd_a), 32'd2);
      chk("lu_fwd_b", 32'(fwd_b), 32'd0);

      // add r3 ; sub r4,r3,r3
      nop(3);
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 1);
      drive(1, 3, 3, 1, 1, 4, 1, 0, 0, 1);
      chk("alu_stall", 32'(stall), 32'd0);
      nop(1);
      chk("alu_fwd_a", 32'(fwd_a), 32'd1);
      chk("alu_fwd_b", 32'(fwd_b), 32'd1);

      // producer r5, two unrelated, reader r5
      nop(3);
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
      drive(1, 5, 0, 1, 0, 11, 1, 0, 0, 1);
      chk("wb_byp_a", 32'(byp_a), 32'd1);
      chk("wb_byp_b", 32'(byp_b), 32'd0);
      nop(1);
      chk("wb_fwd_a", 32'(fwd_a), 32'd0);

      // load to r0, readers of r0
      nop(3);
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
      drive(1, 0, 0, 1, 1, 12, 1, 0, 0, 1);
      chk("r0_stall", 32'(stall), 32'd0);
      drive(1, 0, 0, 1, 1, 12, 1, 0, 0, 1);
      chk("r0_fwd_a", 32'(fwd_a), 32'd0);
      chk("r0_fwd_b", 32'(fwd_b), 32'd0);
      drive(1, 0, 0, 1, 1, 12, 1, 0, 0, 1);
      chk("r0_byp_a", 32'(byp_a), 32'd0);
      chk("r0_byp_b", 32'(byp_b), 32'd0);

      // redirect coinciding with load-use
      nop(3);
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 1);
      drive(1, 8, 0, 1, 0, 9, 1, 0, 1, 1);
      chk("rd_flush_if", 32'(flush_if), 32'd1);
      chk("rd_flush_id", 32'(flush_id), 32'd1);
      chk("rd_flush_ex", 32'(flush_ex), 32'd1);
      chk("rd_stall", 32'(stall), 32'd0);
      chk("rd_bubble", 32'(bubble), 32'd0);
      drive(1, 8, 8, 1, 1, 9, 1, 0, 0, 1);
      chk("rd_fwd_a", 32'(fwd_a), 32'd0);
      chk("rd_fwd_b", 32'(fwd_b), 32'd0);
      chk("rd_ex_invalid", 32'(stall), 32'd0);
      nop(1);
      chk("rd_fwd_a_after", 32'(fwd_a), 32'd0);

      // reset during a load-use condition
      nop(3);
      drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 1);
      drive(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
      chk("rst_lu_stall", 32'(stall), 32'd0);
      chk("rst_lu_bubble", 32'(bubble), 32'd0);
      drive(1, 8, 0, 1, 0, 9, 1, 0, 0, 1);
      chk("rst_lu_residual", 32'(stall), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 1);
         drive(1, 8, 1, 1, 1, 9, 1, 0, 0, 1);
         drive(1, 8, 1, 1, 1, 9, 1, 0, 0, 1);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      nop(1);
      chk("cnt_stall", stall_cnt, 32'd3);
      chk("cnt_flush", flush_cnt, 32'd2);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(1);
      chk("cnt_stall_rst", stall_cnt, 32'd0);
      chk("cnt_flush_rst", flush_cnt, 32'd0);
`endif

      // randomized traffic; a stalled ID instruction is held, as the pipeline would
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         rst_n    = ($urandom_range(0, 99) != 0);
         redirect = ($urandom_range(0, 9) == 0);
         if (!m_stall) begin
            id_valid    = ($urandom_range(0, 9) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            id_rw       = 5'($urandom_range(0, 3));
            id_regwr    = ($urandom_range(0, 3) != 0);
            id_memtoreg = ($urandom_range(0, 2) == 0);
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RIDX_W, default 5, register-index width.
REQ-002 SHALL have parameter NREG, default 32, register count; index 0 is hard-wired zero.
REQ-003 SHALL have ports in this order: clk, rst_n, then the remaining ports; one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 id_valid  in  1  ID stage holds a live instruction.
REQ-007 id_rs, id_rt  in  RIDX_W  ID source indices.
REQ-008 id_use_rs, id_use_rt  in  1  ID instruction reads rs/rt.
REQ-009 id_rw, id_regwr, id_memtoreg  in  RIDX_W/1/1  ID destination, write-enable, load flag.
REQ-010 redirect  in  1  MEM-stage branch taken or jump.
REQ-011 stall  out  1  hold PC and IF/ID register.
REQ-012 bubble  out  1  load NOP controls into ID/EX.
REQ-013 flush_if, flush_id, flush_ex  out  1  clear IF/ID, ID/EX, EX/MEM controls.
REQ-014 fwd_a, fwd_b  out  2  EX operand select: 0 register, 1 EX/MEM ALU, 2 MEM/WB result.
REQ-015 byp_a, byp_b  out  1  ID read port takes WB write data.

Function
REQ-016 SHALL keep shadow records {valid, rw, regwr, memtoreg} for EX, MEM, WB stages, advancing every cycle.
REQ-017 Record is "writer" only when valid, regwr, and rw != 0.
REQ-018 Load-use: EX record is a writer with memtoreg, and rw equals a used ID source with id_valid -> stall=1, bubble=1 combinationally.
REQ-019 On load-use, EX record SHALL become invalid next edge; ID inputs are re-presented the next cycle.
REQ-020 fwd_a/fwd_b SHALL be registered: computed from ID inputs, applied in the consumer's EX cycle (one-cycle latency).
REQ-021 Forward code 1 when current EX record writes the source; else 2 when current MEM record writes it; else 0. The newest producer wins.
REQ-022 byp_a/byp_b SHALL be combinational: 1 when the WB record writes the used ID source.
REQ-023 Index 0 SHALL never match: all fwd codes 0, all byp 0.
REQ-024 redirect=1 -> flush_if=flush_id=flush_ex=1 the same cycle. The ID input and the EX record are captured invalid. The MEM record advances to WB.
REQ-025 Redirect has priority over load-use: stall=0, bubble=0 when both occur.
REQ-026 Bubble, flush, or id_valid=0 SHALL load zero fwd codes.
REQ-027 Two consecutive stalls SHALL NOT occur for a single load.

Reset
REQ-028 rst_n=0 at an edge SHALL invalidate all shadow records and clear fwd_a and fwd_b to 0.
REQ-029 During reset, stall, bubble, flush_* and byp_* SHALL be 0.
REQ-030 Reset mid-stall or mid-flush SHALL discard the event with no residual stall.

Configuration
REQ-031 With HAZARD_PERF_CNT_EN defined, SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-032 stall_cnt SHALL count cycles with stall=1; flush_cnt SHALL count redirect cycles. Both wrap at 2^32, reset to 0.
REQ-033 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-034 Sequence lw r8; add r9,r8,r1: one stall+bubble cycle. Next cycle add in EX with fwd_a=2.
REQ-035 Sequence add r3; sub r4,r3,r3 back-to-back: fwd_a=fwd_b=1 in sub's EX cycle, no stall.
REQ-036 Producer writes r5, then two unrelated instructions, then a reader of r5: byp_a=1 in the reader's ID cycle, fwd_a=0.
REQ-037 Producer writes r0, then a reader of r0: no stall, fwd=0, byp=0.
REQ-038 redirect=1 in the same cycle as a load-use condition: flush_*=1, stall=0. Next cycle EX record invalid, fwd codes 0.
REQ-039 HAZARD_PERF_CNT_EN: three load-use stalls and two redirects -> stall_cnt=3, flush_cnt=2. rst_n=0 then clears both to 0.
